multicore_norm_engine: RTL and testbench

//  Post-accumulation normaliser for an N-core attention datapath. It accepts one row of per-core psum vectors
//  (N_CORE x COL signed lanes) and forms the cross-core L1 sum, sum = sum(|x|).

---
 rtl/norm_pkg.sv | 33 +++
 rtl/seq_udiv.sv | 73 +++++++
 rtl/multicore_norm_engine.sv | 137 +++++++++++++
 tb/tb_multicore_norm_engine.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/norm_pkg.sv
// Shared configuration, state encoding and lane helpers for the multicore normaliser.
package norm_pkg;

  localparam int N_CORE  = 2;
  localparam int COL     = 8;
  localparam int BW_PSUM = 20;
  localparam int FRAC    = 7;

  localparam int NE     = N_CORE * COL;
  localparam int SUM_BW = BW_PSUM + $clog2(NE);
  localparam int DW     = BW_PSUM + FRAC;
  localparam int IDX_W  = (NE > 1) ? $clog2(NE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUM  = 2'd1,
    DIV  = 2'd2,
    HOLD = 2'd3
  } state_t;

  // Lane packing: core c, lane k lives at element index c*COL+k.
  function automatic logic [BW_PSUM-1:0] lane_get(input logic [NE*BW_PSUM-1:0] row, input int idx);
    return row[idx*BW_PSUM +: BW_PSUM];
  endfunction

  // Widening first lets |-2^(BW_PSUM-1)| be represented exactly.
  function automatic logic [SUM_BW-1:0] lane_abs(input logic [BW_PSUM-1:0] v);
    logic [SUM_BW-1:0] w;
    w = {{(SUM_BW-BW_PSUM){v[BW_PSUM-1]}}, v};
    return v[BW_PSUM-1] ? (~w + 1'b1) : w;
  endfunction

endpackage

// File: rtl/seq_udiv.sv
// Restoring unsigned divider, one quotient bit per cycle; the first step runs in the start cycle.
module seq_udiv #(
  parameter int NW     = 27,
  parameter int DW_DIV = 24,
  parameter int ITER   = 27
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [NW-1:0]     dividend,
  input  logic [DW_DIV-1:0] divisor,
  output logic              done,
  output logic [NW-1:0]     quotient
);

  localparam int CW = $clog2(ITER + 1);

  logic [NW-1:0]     q_r, q_cur, q_nxt;
  logic [DW_DIV-1:0] rem_r, rem_cur, rem_nxt;
  logic [DW_DIV-1:0] den_r, den_cur;
  logic [DW_DIV:0]   trial, diff;
  logic [CW-1:0]     cnt;
  logic              run;

  // The step logic reads the new operands directly on start so that ITER steps
  // finish ITER cycles after start, with done following one cycle later.
  always_comb begin
    q_cur   = q_r;
    rem_cur = rem_r;
    den_cur = den_r;
    if (start) begin
      q_cur   = dividend;
      rem_cur = '0;
      den_cur = divisor;
    end
    trial   = {rem_cur, q_cur[NW-1]};
    diff    = trial - {1'b0, den_cur};
    rem_nxt = diff[DW_DIV] ? trial[DW_DIV-1:0] : diff[DW_DIV-1:0];
    q_nxt   = {q_cur[NW-2:0], ~diff[DW_DIV]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_r   <= '0;
      rem_r <= '0;
      den_r <= '0;
      cnt   <= '0;
      run   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        q_r   <= q_nxt;
        rem_r <= rem_nxt;
        den_r <= den_cur;
        cnt   <= CW'(ITER - 1);
        run   <= 1'b1;
      end else if (run) begin
        q_r   <= q_nxt;
        rem_r <= rem_nxt;
        cnt   <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  // A zero divisor would otherwise yield all ones.
  assign quotient = (den_r == '0) ? '0 : q_r;

endmodule

// File: rtl/multicore_norm_engine.sv
// Joint L1 normaliser over N_CORE x COL psum lanes: out = trunc(x * 2^FRAC / sum|x|).
//
// state | meaning
// IDLE  | waiting for a row, in_ready high
// SUM   | L1 sum of the captured row, choose divide or bypass
// DIV   | one element per DW+1 cycles through the shared divider
// HOLD  | result row presented until out_ready
module multicore_norm_engine
  import norm_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_mode,
  input  logic [NE*BW_PSUM-1:0]   in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NE*BW_PSUM-1:0]   out_data,
  output logic [SUM_BW-1:0]       out_sum,
  output logic                    out_div_zero,
  output logic                    busy
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NE - 1);

  state_t                  state;
  logic [NE*BW_PSUM-1:0]   data_r;
  logic                    mode_r;
  logic [IDX_W-1:0]        idx;
  logic                    div_start;
  logic                    div_done;
  logic [DW-1:0]           quotient;
  logic [DW-1:0]           dividend;
  logic [SUM_BW-1:0]       sum_c;
  logic [BW_PSUM-1:0]      cur_lane;
  logic [SUM_BW-1:0]       cur_abs;
  logic [BW_PSUM-1:0]      mag;
  logic [BW_PSUM-1:0]      wb_lane;
  logic                    unused_bits;

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < NE; i++) begin
      sum_c = sum_c + lane_abs(lane_get(data_r, i));
    end
  end

  // |x| <= sum, so the quotient magnitude never exceeds 2^FRAC and fits a lane.
  always_comb begin
    cur_lane = lane_get(data_r, int'(idx));
    cur_abs  = lane_abs(cur_lane);
    dividend = {cur_abs[BW_PSUM-1:0], {FRAC{1'b0}}};
    mag      = quotient[BW_PSUM-1:0];
    wb_lane  = cur_lane[BW_PSUM-1] ? (~mag + 1'b1) : mag;
  end

  assign unused_bits = ^{cur_abs[SUM_BW-1:BW_PSUM], quotient[DW-1:BW_PSUM]};

  seq_udiv #(
    .NW    (DW),
    .DW_DIV(SUM_BW),
    .ITER  (DW)
  ) u_div (
    .clk     (clk),
    .reset   (reset),
    .start   (div_start),
    .dividend(dividend),
    .divisor (out_sum),
    .done    (div_done),
    .quotient(quotient)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_sum      <= '0;
      out_div_zero <= 1'b0;
      busy         <= 1'b0;
      data_r       <= '0;
      mode_r       <= 1'b0;
      idx          <= '0;
      div_start    <= 1'b0;
    end else begin
      div_start <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_r   <= in_data;
            mode_r   <= in_mode;
            state    <= SUM;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        SUM: begin
          out_sum      <= sum_c;
          out_div_zero <= (sum_c == '0);
          if (mode_r || (sum_c == '0)) begin
            out_data  <= mode_r ? data_r : '0;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            idx       <= '0;
            div_start <= 1'b1;
            state     <= DIV;
          end
        end
        DIV: begin
          if (div_done) begin
            out_data[int'(idx)*BW_PSUM +: BW_PSUM] <= wb_lane;
            if (idx == IDX_LAST) begin
              out_valid <= 1'b1;
              state     <= HOLD;
            end else begin
              idx       <= idx + 1'b1;
              div_start <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multicore_norm_engine.sv
// Directed bench for multicore_norm_engine with hand-computed expected rows.
module tb_multicore_norm_engine;
  import norm_pkg::*;

  localparam int W = NE * BW_PSUM;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic              in_mode;
  logic [W-1:0]      in_data;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_data;
  logic [SUM_BW-1:0] out_sum;
  logic              out_div_zero;
  logic              busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicore_norm_engine dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_mode     (in_mode),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_sum     (out_sum),
    .out_div_zero(out_div_zero),
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] put(input logic [W-1:0] row, input int k, input int v);
    logic [W-1:0] r;
    r = row;
    r[k*BW_PSUM +: BW_PSUM] = BW_PSUM'(v);
    return r;
  endfunction

  // Offers a row, then counts cycles until out_valid (accept cycle = 0).
  task automatic send_row(input logic [W-1:0] d, input logic m, output int lat);
    @(negedge clk);
    chk("in_ready_before_send", W'(in_ready), W'(1));
    in_data  = d;
    in_mode  = m;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 1000) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic take_row();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  logic [W-1:0] row1, row2, exp2, row3, exp3, row5;
  int lat;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_mode   = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    row1 = '0;
    for (int k = 0; k < NE; k++) row1 = put(row1, k, (k < COL) ? 10 : -6);
    row2 = put(put(put('0, 0, -7), 1, -2), 2, 1);
    exp2 = put(put(put('0, 0, -89), 1, -25), 2, 12);
    row3 = put('0, NE - 1, -524288);
    exp3 = put('0, NE - 1, -128);
    row5 = '0;
    for (int k = 0; k < NE; k++) row5 = put(row5, k, 5);

    repeat (3) @(negedge clk);
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_out_data", out_data, '0);
    chk("rst_out_sum", W'(out_sum), W'(0));
    chk("rst_div_zero", W'(out_div_zero), W'(0));
    chk("rst_busy", W'(busy), W'(0));
    reset = 1'b0;

    // 128 total: every lane maps back to itself.
    send_row(row1, 1'b0, lat);
    chk("t1_latency", W'(lat), W'(450));
    chk("t1_out_data", out_data, row1);
    chk("t1_out_sum", W'(out_sum), W'(128));
    chk("t1_div_zero", W'(out_div_zero), W'(0));
    chk("t1_busy", W'(busy), W'(1));
    chk("t1_in_ready", W'(in_ready), W'(0));
    take_row();
    chk("t1_out_valid_after", W'(out_valid), W'(0));
    chk("t1_in_ready_after", W'(in_ready), W'(1));
    chk("t1_busy_after", W'(busy), W'(0));

    send_row(row2, 1'b0, lat);
    chk("t2_latency", W'(lat), W'(450));
    chk("t2_out_data", out_data, exp2);
    chk("t2_out_sum", W'(out_sum), W'(10));
    take_row();

    send_row(row3, 1'b0, lat);
    chk("t3_out_data", out_data, exp3);
    chk("t3_out_sum", W'(out_sum), W'(524288));
    chk("t3_div_zero", W'(out_div_zero), W'(0));
    take_row();

    send_row('0, 1'b0, lat);
    chk("t4_zero_latency", W'(lat), W'(2));
    chk("t4_zero_div_zero", W'(out_div_zero), W'(1));
    chk("t4_zero_out_data", out_data, '0);
    chk("t4_zero_out_sum", W'(out_sum), W'(0));
    take_row();

    send_row(row5, 1'b1, lat);
    chk("t4_mode1_latency", W'(lat), W'(2));
    chk("t4_mode1_out_data", out_data, row5);
    chk("t4_mode1_out_sum", W'(out_sum), W'(80));
    chk("t4_mode1_div_zero", W'(out_div_zero), W'(0));

    // Held output with a competing row offered the whole time.
    in_data  = row1;
    in_mode  = 1'b1;
    in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("t5_hold_data", out_data, row5);
      chk("t5_hold_in_ready", W'(in_ready), W'(0));
      chk("t5_hold_valid", W'(out_valid), W'(1));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("t5_after_hs_valid", W'(out_valid), W'(0));
    chk("t5_after_hs_sum_kept", W'(out_sum), W'(80));
    @(negedge clk);
    in_valid = 1'b0;
    chk("t5_second_in_sum", W'(out_valid), W'(0));
    @(negedge clk);
    chk("t5_second_valid", W'(out_valid), W'(1));
    chk("t5_second_data", out_data, row1);
    chk("t5_second_sum", W'(out_sum), W'(128));
    take_row();

    // Reset while element 7 is being divided.
    @(negedge clk);
    in_data  = row2;
    in_mode  = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (202) @(negedge clk);
    chk("t6_pre_reset_valid", W'(out_valid), W'(0));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t6_rst_out_valid", W'(out_valid), W'(0));
    chk("t6_rst_in_ready", W'(in_ready), W'(1));
    chk("t6_rst_busy", W'(busy), W'(0));
    chk("t6_rst_out_data", out_data, '0);
    send_row(row2, 1'b0, lat);
    chk("t6_latency", W'(lat), W'(450));
    chk("t6_out_data", out_data, exp2);
    chk("t6_out_sum", W'(out_sum), W'(10));
    take_row();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
